// File: rtl/mmio_led_capture_if.sv
// Core store-bus view used by mmio_led_capture: strobe, address and data.
// The core side drives it (master); the LED capture port only observes (slave).
interface mmio_led_capture_if #(
    parameter int DATA_W = 32
);
    logic              mem_write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;

    modport master (output mem_write, output addr, output wdata);
    modport slave  (input  mem_write, input  addr, input  wdata);
endinterface

// File: rtl/mmio_led_capture.sv
// Memory-mapped LED port: keeps the last NCH stores to BASE_ADDR and shows one byte, manual or auto-scrolled.
// Optional MLC_CLEAR_EN: a store to BASE_ADDR+4 wipes the history and count.
module mmio_led_capture #(
    parameter int          DATA_W     = 32,
    parameter int          LED_W      = 8,
    parameter int          NCH        = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0064,
    parameter int          SCROLL_DIV = 25_000_000
) (
    input  logic                              clk,
    input  logic                              reset,
    mmio_led_capture_if.slave                 bus,
    input  logic                              mode,
    input  logic [$clog2(NCH)-1:0]            sel,
    input  logic [$clog2(DATA_W/LED_W)-1:0]   byte_sel,
    output logic [LED_W-1:0]                  leds,
    output logic [$clog2(NCH):0]              count,
    output logic                              new_pulse
);
    localparam int NB    = DATA_W / LED_W;
    localparam int EW    = $clog2(NCH);
    localparam int BW    = $clog2(NB);
    localparam int CW    = EW + 1;
    localparam int NVIEW = 1 << EW;
    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [DATA_W-1:0] r_hist [NCH];
    logic [CW-1:0]     r_count;
    logic [LED_W-1:0]  r_leds;
    logic              r_pulse;
    logic [DIV_W-1:0]  r_div;
    logic [EW-1:0]     r_e;
    logic [BW-1:0]     r_b;
    logic              r_mode_d;

    logic              w_cap;
    logic              w_clr;
    logic [DIV_W-1:0]  w_div_nxt;
    logic [EW-1:0]     w_e_nxt;
    logic [BW-1:0]     w_b_nxt;
    logic [LED_W-1:0]  w_leds_nxt;
    logic [DATA_W-1:0] w_view [NVIEW];

    assign w_cap = bus.mem_write && (bus.addr == BASE_ADDR);
`ifdef MLC_CLEAR_EN
    assign w_clr = bus.mem_write && (bus.addr == BASE_ADDR + 32'd4);
`else
    assign w_clr = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) r_hist[i] <= '0;
            r_count <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_cap;
            if (w_clr) begin
                for (int i = 0; i < NCH; i++) r_hist[i] <= '0;
                r_count <= '0;
            end else if (w_cap) begin
                for (int i = NCH - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
                r_hist[0] <= bus.wdata;
                if (r_count != CW'(NCH)) r_count <= r_count + 1'b1;
            end
        end
    end

    // Padded to a power of two so out-of-range selects and stale slots read as zero.
    always_comb begin
        for (int i = 0; i < NVIEW; i++) w_view[i] = '0;
        for (int i = 0; i < NCH; i++) begin
            if (i < int'(r_count)) w_view[i] = r_hist[i];
        end
    end

    always_comb begin
        w_div_nxt = r_div;
        w_e_nxt   = r_e;
        w_b_nxt   = r_b;
        if (mode) begin
            if (!r_mode_d) begin
                w_div_nxt = '0;
                w_e_nxt   = '0;
                w_b_nxt   = '0;
            end else if (r_div == DIV_W'(SCROLL_DIV - 1)) begin
                w_div_nxt = '0;
                if (r_b == BW'(NB - 1)) begin
                    w_b_nxt = '0;
                    w_e_nxt = (r_e == EW'(NCH - 1)) ? '0 : r_e + 1'b1;
                end else begin
                    w_b_nxt = r_b + 1'b1;
                end
            end else begin
                w_div_nxt = r_div + 1'b1;
            end
        end
    end

    // Scroll display follows the pointer value being loaded on this edge.
    always_comb begin
        w_leds_nxt = '0;
        if (mode) w_leds_nxt = w_view[w_e_nxt][w_b_nxt*LED_W +: LED_W];
        else      w_leds_nxt = w_view[sel][byte_sel*LED_W +: LED_W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div    <= '0;
            r_e      <= '0;
            r_b      <= '0;
            r_mode_d <= 1'b0;
            r_leds   <= '0;
        end else begin
            r_div    <= w_div_nxt;
            r_e      <= w_e_nxt;
            r_b      <= w_b_nxt;
            r_mode_d <= mode;
            r_leds   <= w_leds_nxt;
        end
    end

    assign leds      = r_leds;
    assign count     = r_count;
    assign new_pulse = r_pulse;
endmodule
